// File: rtl/muldiv_exec_pkg.sv
// Shared definitions for the HI/LO multiply/divide execute unit:
// op codes from decode, FSM state type and op classification helpers.
package muldiv_exec_pkg;

    localparam int DEFAULT_WIDTH = 32;

    localparam logic [7:0] EXE_MULT_OP  = 8'h18;
    localparam logic [7:0] EXE_MULTU_OP = 8'h19;
    localparam logic [7:0] EXE_DIV_OP   = 8'h1A;
    localparam logic [7:0] EXE_DIVU_OP  = 8'h1B;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_DONE
    } state_e;

    function automatic logic is_muldiv_op(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP) ||
               (op == EXE_DIV_OP)  || (op == EXE_DIVU_OP);
    endfunction

    function automatic logic is_mul_op(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_MULTU_OP);
    endfunction

    function automatic logic is_signed_op(input logic [7:0] op);
        return (op == EXE_MULT_OP) || (op == EXE_DIV_OP);
    endfunction

endpackage

// File: rtl/muldiv_exec_div_radix2.sv
// Iterative restoring divider: one quotient bit per cycle on operand magnitudes,
// sign fixups applied to the final step so done_o carries the finished result.
module div_radix2 #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             start_i,
    input  logic             cancel_i,
    input  logic             signed_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    output logic             done_o,
    output logic [WIDTH-1:0] quot_o,
    output logic [WIDTH-1:0] rem_o
);

    localparam int CW = $clog2(WIDTH);

    logic             busy_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;
    logic [WIDTH-1:0] quo_q;
    logic [WIDTH-1:0] dvs_q;
    logic             neg_quot_q;
    logic             neg_rem_q;

    logic [WIDTH-1:0] a_mag;
    logic [WIDTH-1:0] b_mag;
    logic [WIDTH:0]   shifted;
    logic [WIDTH:0]   diff;
    logic             take;
    logic [WIDTH-1:0] rem_next;
    logic [WIDTH-1:0] quo_next;
    logic             last_step;

    assign a_mag = (signed_i && a_i[WIDTH-1]) ? (~a_i + 1'b1) : a_i;
    assign b_mag = (signed_i && b_i[WIDTH-1]) ? (~b_i + 1'b1) : b_i;

    // Shift the next dividend bit into the partial remainder, keep the subtraction if it did not borrow.
    assign shifted  = {rem_q, quo_q[WIDTH-1]};
    assign diff     = shifted - {1'b0, dvs_q};
    assign take     = ~diff[WIDTH];
    assign rem_next = take ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
    assign quo_next = {quo_q[WIDTH-2:0], take};

    assign last_step = busy_q && (cnt_q == CW'(WIDTH - 1));
    assign done_o    = last_step && !cancel_i;
    assign quot_o    = neg_quot_q ? (~quo_next + 1'b1) : quo_next;
    assign rem_o     = neg_rem_q ? (~rem_next + 1'b1) : rem_next;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            busy_q     <= 1'b0;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
            dvs_q      <= '0;
            neg_quot_q <= 1'b0;
            neg_rem_q  <= 1'b0;
        end else if (cancel_i) begin
            busy_q <= 1'b0;
            cnt_q  <= '0;
        end else if (start_i) begin
            busy_q     <= 1'b1;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= a_mag;
            dvs_q      <= b_mag;
            neg_quot_q <= signed_i && (a_i[WIDTH-1] ^ b_i[WIDTH-1]);
            neg_rem_q  <= signed_i && a_i[WIDTH-1];
        end else if (busy_q) begin
            rem_q <= rem_next;
            quo_q <= quo_next;
            if (last_step) begin
                busy_q <= 1'b0;
                cnt_q  <= '0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
            end
        end
    end

endmodule

// File: rtl/muldiv_exec.sv
// HI/LO execute unit: registered MULT/MULTU, iterative DIV/DIVU, pipeline stall
// while busy and a one-cycle done pulse that writes {hi,lo}.
module muldiv_exec
    import muldiv_exec_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [7:0]       alucontrol_i,
    input  logic             start_i,
    input  logic             cancel_i,
    input  logic [WIDTH-1:0] src_a_i,
    input  logic [WIDTH-1:0] src_b_i,
    output logic             stall_o,
    output logic             done_o,
    output logic [WIDTH-1:0] hi_o,
    output logic [WIDTH-1:0] lo_o
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, b_q;
    logic             signed_q;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;

    logic             issue;
    logic             div_by_zero;
    logic             div_start;
    logic             div_done;
    logic [WIDTH-1:0] div_quot;
    logic [WIDTH-1:0] div_rem;

    logic [2*WIDTH-1:0] a_ext, b_ext, product;

    assign issue       = start_i && is_muldiv_op(alucontrol_i) && !cancel_i;
    assign div_by_zero = (src_b_i == '0);
    assign div_start   = (state_q == ST_IDLE) && issue && !is_mul_op(alucontrol_i) && !div_by_zero;

    // Low 2*WIDTH bits of the extended product equal the signed or unsigned product.
    assign a_ext   = signed_q ? {{WIDTH{a_q[WIDTH-1]}}, a_q} : {{WIDTH{1'b0}}, a_q};
    assign b_ext   = signed_q ? {{WIDTH{b_q[WIDTH-1]}}, b_q} : {{WIDTH{1'b0}}, b_q};
    assign product = a_ext * b_ext;

    div_radix2 #(.WIDTH(WIDTH)) u_div (
        .clk      (clk),
        .resetn   (resetn),
        .start_i  (div_start),
        .cancel_i (cancel_i),
        .signed_i (is_signed_op(alucontrol_i)),
        .a_i      (src_a_i),
        .b_i      (src_b_i),
        .done_o   (div_done),
        .quot_o   (div_quot),
        .rem_o    (div_rem)
    );

    always_comb begin
        state_d = state_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        stall_o = 1'b0;
        done_o  = 1'b0;
        case (state_q)
            ST_IDLE: begin
                stall_o = issue;
                if (issue) begin
                    if (is_mul_op(alucontrol_i)) begin
                        state_d = ST_MUL;
                    end else if (div_by_zero) begin
                        state_d = ST_DONE;
                        hi_d    = src_a_i;
                        lo_d    = '1;
                    end else begin
                        state_d = ST_DIV;
                    end
                end
            end
            ST_MUL: begin
                stall_o = 1'b1;
                hi_d    = product[2*WIDTH-1:WIDTH];
                lo_d    = product[WIDTH-1:0];
                state_d = ST_DONE;
            end
            ST_DIV: begin
                stall_o = 1'b1;
                if (div_done) begin
                    hi_d    = div_rem;
                    lo_d    = div_quot;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                done_o  = 1'b1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
        // A flush abandons whatever is in flight and leaves the previous HI/LO intact.
        if (cancel_i) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_o  = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
        end else begin
            state_q <= state_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            if ((state_q == ST_IDLE) && issue) begin
                a_q      <= src_a_i;
                b_q      <= src_b_i;
                signed_q <= is_signed_op(alucontrol_i);
            end
        end
    end

    assign hi_o = hi_q;
    assign lo_o = lo_q;

endmodule

// File: tb/tb_muldiv_exec.sv
// Self-checking bench for muldiv_exec: directed vector table, random ops against
// an arithmetic reference model, and hand sequences for held start, flush and reset.
module tb_muldiv_exec;

    logic        clk;
    logic        resetn;
    logic [7:0]  alucontrol;
    logic        start;
    logic        cancel;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        stall_o;
    logic        done_o;
    logic [31:0] hi_o;
    logic [31:0] lo_o;

    int errors = 0;
    int checks = 0;

    muldiv_exec #(.WIDTH(32)) dut (
        .clk          (clk),
        .resetn       (resetn),
        .alucontrol_i (alucontrol),
        .start_i      (start),
        .cancel_i     (cancel),
        .src_a_i      (src_a),
        .src_b_i      (src_b),
        .stall_o      (stall_o),
        .done_o       (done_o),
        .hi_o         (hi_o),
        .lo_o         (lo_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    typedef struct {
        logic [7:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        int          lat;
        int          stalls;
    } vec_t;

    vec_t vecs[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference: plain arithmetic from the op definitions, including the div-by-zero and overflow rules.
    function automatic logic [63:0] model(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sa;
        int          sb;
        longint      sp;
        logic [63:0] up;
        sa = a;
        sb = b;
        case (op)
            8'h18: begin
                sp = longint'(sa) * longint'(sb);
                return sp;
            end
            8'h19: begin
                up = {32'b0, a} * {32'b0, b};
                return up;
            end
            8'h1A: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                if (a == 32'h80000000 && b == 32'hFFFFFFFF) return {32'h0, 32'h80000000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 32'h0) return {a, 32'hFFFFFFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    function automatic int model_lat(input logic [7:0] op, input logic [31:0] b);
        if (op == 8'h18 || op == 8'h19) return 2;
        if (b == 32'h0) return 1;
        return 33;
    endfunction

    // Issue one op (start high for the issue cycle only) and observe until done_o or the budget runs out.
    task automatic run_op(input logic [7:0] op, input logic [31:0] a, input logic [31:0] b,
                          output int lat, output int stalls,
                          output logic [31:0] hi, output logic [31:0] lo);
        lat    = -1;
        stalls = 0;
        hi     = 'x;
        lo     = 'x;
        alucontrol = op;
        src_a      = a;
        src_b      = b;
        start      = 1'b1;
        for (int k = 0; k < 50; k++) begin
            @(negedge clk);
            if (stall_o) stalls++;
            if (done_o) begin
                lat = k;
                hi  = hi_o;
                lo  = lo_o;
            end
            @(posedge clk);
            #1;
            start = 1'b0;
            if (lat >= 0) break;
        end
    endtask

    int          lat;
    int          stalls;
    int          done_cnt;
    int          stall_cnt;
    logic [31:0] hi;
    logic [31:0] lo;
    logic [63:0] exp;
    logic [7:0]  rop;
    logic [31:0] ra;
    logic [31:0] rb;

    initial begin
        resetn     = 1'b0;
        start      = 1'b0;
        cancel     = 1'b0;
        alucontrol = 8'h00;
        src_a      = 32'h0;
        src_b      = 32'h0;

        vecs.push_back('{8'h18, 32'hFFFFFFFE, 32'h00000003, 32'hFFFFFFFF, 32'hFFFFFFFA, 2, 2});
        vecs.push_back('{8'h19, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 2, 2});
        vecs.push_back('{8'h1A, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD, 33, 33});
        vecs.push_back('{8'h1B, 32'hFFFFFFF9, 32'h00000002, 32'h00000001, 32'h7FFFFFFC, 33, 33});
        vecs.push_back('{8'h1B, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF, 1, 1});
        vecs.push_back('{8'h1A, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, 33, 33});
        vecs.push_back('{8'h1A, 32'd100,      32'h00000000, 32'd100,      32'hFFFFFFFF, 1, 1});
        vecs.push_back('{8'h1A, 32'h00000007, 32'hFFFFFFFE, 32'h00000001, 32'hFFFFFFFD, 33, 33});

        repeat (3) @(posedge clk);
        #1;
        check("reset_stall", {63'b0, stall_o}, 64'd0);
        check("reset_done",  {63'b0, done_o},  64'd0);
        check("reset_hi",    {32'b0, hi_o},    64'd0);
        check("reset_lo",    {32'b0, lo_o},    64'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, lat, stalls, hi, lo);
            check($sformatf("vec%0d_lat", i),    64'(lat),    64'(vecs[i].lat));
            check($sformatf("vec%0d_stalls", i), 64'(stalls), 64'(vecs[i].stalls));
            check($sformatf("vec%0d_hi", i),     {32'b0, hi}, {32'b0, vecs[i].hi});
            check($sformatf("vec%0d_lo", i),     {32'b0, lo}, {32'b0, vecs[i].lo});
        end

        for (int i = 0; i < 30; i++) begin
            rop = 8'h18 + 8'($urandom_range(0, 3));
            ra  = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'h0;
                1:       rb = $urandom_range(1, 15);
                2:       rb = 32'h0 - $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            run_op(rop, ra, rb, lat, stalls, hi, lo);
            exp = model(rop, ra, rb);
            check($sformatf("rnd%0d_op%0h_lat", i, rop), 64'(lat), 64'(model_lat(rop, rb)));
            check($sformatf("rnd%0d_op%0h_hilo a=%0h b=%0h", i, rop, ra, rb), {hi, lo}, exp);
        end

        // start held through DONE must not launch a second operation
        alucontrol = 8'h18;
        src_a      = 32'd5;
        src_b      = 32'd6;
        start      = 1'b1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("held_done",  {63'b0, done_o},  64'd1);
        check("held_stall", {63'b0, stall_o}, 64'd0);
        check("held_lo",    {32'b0, lo_o},    64'd30);
        @(posedge clk);
        #1;
        start = 1'b0;
        @(negedge clk);
        check("held_after_stall", {63'b0, stall_o}, 64'd0);
        check("held_after_done",  {63'b0, done_o},  64'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        check("held_after_done2", {63'b0, done_o}, 64'd0);
        @(posedge clk);
        #1;

        // flush at divide iteration 10
        alucontrol = 8'h1A;
        src_a      = 32'd1000;
        src_b      = 32'd7;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        cancel = 1'b1;
        @(posedge clk);
        #1;
        cancel = 1'b0;
        @(negedge clk);
        check("cancel_stall", {63'b0, stall_o}, 64'd0);
        check("cancel_done",  {63'b0, done_o},  64'd0);
        check("cancel_hi",    {32'b0, hi_o},    64'd0);
        check("cancel_lo",    {32'b0, lo_o},    64'd30);
        done_cnt = 0;
        for (int k = 0; k < 30; k++) begin
            @(negedge clk);
            if (done_o) done_cnt++;
        end
        check("cancel_no_done", 64'(done_cnt), 64'd0);
        @(posedge clk);
        #1;
        run_op(8'h18, 32'hFFFFFFFE, 32'd3, lat, stalls, hi, lo);
        check("post_cancel_lat",  64'(lat),  64'd2);
        check("post_cancel_hilo", {hi, lo},  64'hFFFFFFFF_FFFFFFFA);

        // asynchronous reset at divide iteration 20
        alucontrol = 8'h1B;
        src_a      = 32'd1000;
        src_b      = 32'd7;
        start      = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("rst_mid_hi",    {32'b0, hi_o},    64'd0);
        check("rst_mid_lo",    {32'b0, lo_o},    64'd0);
        check("rst_mid_stall", {63'b0, stall_o}, 64'd0);
        check("rst_mid_done",  {63'b0, done_o},  64'd0);
        @(negedge clk);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // non HI/LO op is ignored
        alucontrol = 8'h24;
        src_a      = 32'h12345678;
        src_b      = 32'h0F0F0F0F;
        start      = 1'b1;
        done_cnt   = 0;
        stall_cnt  = 0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clk);
            if (done_o) done_cnt++;
            if (stall_o) stall_cnt++;
        end
        check("and_no_stall", 64'(stall_cnt), 64'd0);
        check("and_no_done",  64'(done_cnt),  64'd0);
        @(posedge clk);
        #1;
        start = 1'b0;

        run_op(8'h1B, 32'd1000, 32'd7, lat, stalls, hi, lo);
        check("post_rst_lat",  64'(lat), 64'd33);
        check("post_rst_hilo", {hi, lo}, {32'd6, 32'd142});

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
